// File: rtl/rv_lsu.sv
// Load/store unit: turns one core request into one or two bus beats and returns a sign/zero-extended result.
// LSU_MISALIGNED_EN enables two-beat split accesses; without it any misaligned access is rejected with rsp_err.
module rv_lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int BW = 2 * NB;

    // Handshakes: a transfer happens on the rising edge where valid && ready; valid never waits on ready.
    typedef enum logic [2:0] {IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata0_q, rdata0_d;
    logic [XLEN-1:0]   rdata1_q, rdata1_d;
    logic              err_q, err_d;
    logic              split_q, split_d;

    logic [OW-1:0]     req_off;
    logic [3:0]        req_len;
    logic              req_reject;
    logic              req_split;

    assign req_off = req_addr[OW-1:0];
    assign req_len = 4'd1 << req_size;

`ifdef LSU_MISALIGNED_EN
    assign req_split  = (int'(req_off) + int'(req_len)) > NB;
    assign req_reject = (XLEN == 32) && (req_size == 2'd3);
`else
    logic req_misal;
    assign req_misal  = (int'(req_off) & (int'(req_len) - 1)) != 0;
    assign req_split  = 1'b0;
    assign req_reject = ((XLEN == 32) && (req_size == 2'd3)) || req_misal;
`endif

    logic [OW-1:0]     off_q;
    logic [3:0]        len_q;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [BW-1:0]     be_full;
    logic [2*XLEN-1:0] w_full;
    logic [XLEN-1:0]   ld_raw, ld_tmp, ld_ext;
    int                shamt;

    assign off_q   = addr_q[OW-1:0];
    assign len_q   = 4'd1 << size_q;
    assign addr0   = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
    assign addr1   = addr0 + ADDR_W'(NB);
    // Byte enables and data are built over a double-width window; the high half feeds the second beat.
    assign be_full = BW'((1 << len_q) - 1) << off_q;
    assign w_full  = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
    assign ld_raw  = XLEN'({rdata1_q, rdata0_q} >> {off_q, 3'b000});

    always_comb begin
        shamt = XLEN - 8 * int'(len_q);
        if (shamt < 0) shamt = 0;
        ld_tmp = ld_raw << shamt;
        ld_ext = uns_q ? (ld_tmp >> shamt) : $unsigned($signed(ld_tmp) >>> shamt);
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        mem_valid = (state_q == BEAT0) || (state_q == BEAT1);
        mem_we    = mem_valid && we_q;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        if (state_q == BEAT0) begin
            mem_addr  = addr0;
            mem_be    = be_full[NB-1:0];
            mem_wdata = w_full[XLEN-1:0];
        end else if (state_q == BEAT1) begin
            mem_addr  = addr1;
            mem_be    = be_full[BW-1:NB];
            mem_wdata = w_full[2*XLEN-1:XLEN];
        end
        rsp_valid = (state_q == RESP);
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = (rsp_valid && !err_q && !we_q) ? ld_ext : '0;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        err_d    = err_q;
        split_d  = split_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    we_d     = req_we;
                    size_d   = req_size;
                    uns_d    = req_unsigned;
                    wdata_d  = req_wdata;
                    rdata0_d = '0;
                    rdata1_d = '0;
                    err_d    = req_reject;
                    split_d  = req_split;
                    state_d  = req_reject ? RESP : BEAT0;
                end
            end
            BEAT0: if (mem_ready) state_d = WAIT0;
            WAIT0: begin
                if (mem_rvalid) begin
                    rdata0_d = mem_rdata;
                    err_d    = mem_err;
                    state_d  = (split_q && !mem_err) ? BEAT1 : RESP;
                end
            end
            BEAT1: if (mem_ready) state_d = WAIT1;
            WAIT1: begin
                if (mem_rvalid) begin
                    rdata1_d = mem_rdata;
                    err_d    = mem_err;
                    state_d  = RESP;
                end
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            size_q   <= 2'd0;
            uns_q    <= 1'b0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            err_q    <= 1'b0;
            split_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            err_q    <= err_d;
            split_q  <= split_d;
        end
    end
endmodule
